alu_dispatch_ctrl: RTL
======================

Name: alu_dispatch_ctrl

Overview:
Sequential front-end of the ALU that accepts one operation at a time over a valid/ready handshake. It latches the operation and operands and drives the 2-bit unit select plus enable into the 2-to-4 unit decoder. It then waits for the selected functional unit to signal done and returns the result over a second valid/ready handshake. A timeout counter aborts operations to units that never respond.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 15, max cycles in WAIT before abort; range 1..(2**CNT_W - 1)
CNT_W, 4, timeout counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_ready  out  1  controller can accept an operation
op_code  in  4  [3:2] unit select (0 add, 1 logic, 2 shift, 3 mul); [1:0] unit function
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
unit_sel  out  2  to decoder I1,I0 (unit_sel[1]=I1)
unit_en  out  1  to decoder En
unit_func  out  2  function code to all units
unit_a  out  WIDTH  latched operand A
unit_b  out  WIDTH  latched operand B
unit_done  in  1  selected unit finished; qualifies unit_result
unit_result  in  WIDTH  selected unit result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
res_err  out  1  result is a timeout abort; valid with res_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0 except op_ready=1; counter=0. Reset mid-operation discards the in-flight op, and unit_en drops immediately.
- All outputs registered or decoded from state only; no combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: op_ready=1. On op_valid&&op_ready, latch unit_sel=op_code[3:2], unit_func=op_code[1:0], unit_a, unit_b. Go to ISSUE. unit_done is ignored.
- ISSUE (exactly 1 cycle): unit_en=1, counter cleared.
  - If unit_done=1: capture result=unit_result, res_err=0, go to RESP.
  - Otherwise go to WAIT.
- WAIT: unit_en=1, counter increments every cycle.
  - unit_done=1: capture result, res_err=0, go to RESP.
  - Else, if counter==TIMEOUT-1: result=0, res_err=1, go to RESP.
  - unit_done has priority over the timeout in the same cycle.
- RESP: unit_en=0, res_valid=1. result and res_err are held stable until res_ready=1, then go to IDLE and res_valid drops. unit_done is ignored.
- unit_sel, unit_func, unit_a and unit_b hold their last latched values outside ISSUE/WAIT. They change only on an accept.
- Latency: accept at edge N, so unit_en is high in cycle N+1. A single-cycle unit (done in ISSUE) gives res_valid at N+2. A unit responding after k WAIT cycles gives res_valid at N+2+k.
- Minimum spacing between accepts is 3 cycles, with res_ready held high.
- op_valid while busy: the op is not accepted (op_ready=0). The requester must hold op_valid and its data stable.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset, then op_code=4'b0001, a=5, b=7, unit_done in ISSUE with unit_result=12 -> unit_sel=0, unit_en high 1 cycle, res_valid 2 cycles after accept, result=12, res_err=0.
- op_code=4'b1110 (mul), unit_done 4 cycles into WAIT, result=32'hDEADBEEF -> unit_sel=3, unit_func=2, unit_en high 5 cycles, result=DEADBEEF.
- op_code=4'b1000, unit_done never asserted -> after 15 WAIT cycles res_valid=1, res_err=1, result=0.
- unit_done and timeout in the same cycle -> res_err=0, result captured.
- res_ready held low 3 cycles in RESP, with a second op_valid asserted -> result stable, op_ready=0. The second op is accepted only on the first IDLE cycle after res_ready=1.
- rst_n pulsed low during WAIT -> unit_en, busy and res_valid go to 0 immediately, op_ready=1. A new op then completes normally.

Source files
------------

// File: rtl/alu_dispatch_ctrl.sv
// ALU dispatch controller: accepts one operation, issues it to the selected unit,
// waits for done (or aborts on timeout) and returns the result over a handshake.
module alu_dispatch_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [1:0]       unit_sel,
  output logic             unit_en,
  output logic [1:0]       unit_func,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture, abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (unit_done) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still wins over the abort.
        if (unit_done) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (cnt == TO_LAST) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_sel  <= '0;
      unit_func <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
    end else if (accept) begin
      unit_sel  <= op_code[3:2];
      unit_func <= op_code[1:0];
      unit_a    <= op_a;
      unit_b    <= op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      res_err <= 1'b0;
    end else if (capture) begin
      result  <= unit_result;
      res_err <= 1'b0;
    end else if (abort) begin
      result  <= '0;
      res_err <= 1'b1;
    end
  end

  // Handshake and enable outputs are pure decodes of the state register.
  assign op_ready  = (state == IDLE);
  assign unit_en   = (state == ISSUE) || (state == WAIT);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
